// File: rtl/pwm_audio_out.sv
// pwm_audio_out: FIFO-buffered sample sink that turns unsigned W-bit samples into a 1-bit PWM stream.
// Optional: define PWM_UNDERRUN_MUTE_EN to load midscale instead of holding the last sample on underrun.
module pwm_audio_out #(
  parameter int W      = 8,
  parameter int DEPTH  = 4,
  parameter int REPEAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [W-1:0]           s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   pwm_out,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = 8;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [W-1:0]  MIDSCALE = {1'b1, {(W-1){1'b0}}};

  function automatic logic [W-1:0] underrun_duty(input logic [W-1:0] last);
    underrun_duty = last;
`ifdef PWM_UNDERRUN_MUTE_EN
    underrun_duty = MIDSCALE;
`endif
  endfunction

  function automatic logic pwm_level(input logic [W-1:0] c, input logic [W-1:0] d);
    return c < d;
  endfunction

  logic [1:0]    rst_sync;
  logic          rst_n_i;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [W-1:0]  head;

  logic [W-1:0]  cnt;
  logic [RW-1:0] rep;
  logic          boundary;
  logic          load;
  logic [W-1:0]  duty;
  logic [W-1:0]  duty_eff;

  // Reset asserts asynchronously, deasserts after two clk edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_i = rst_sync[1];

  // Input stage: FIFO write side; s_ready depends only on the current level.
  assign full       = (level == FULL_LVL);
  assign empty      = (level == '0);
  assign s_ready    = !full;
  assign push       = s_valid && s_ready;
  assign fifo_level = level;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Frame stage: boundary detection, repeat slotting and duty selection.
  assign boundary = en && (cnt == '0);
  assign load     = boundary && (rep == '0);
  assign pop      = load && !empty;

  always_comb begin
    duty_eff = duty;
    if (load) duty_eff = empty ? underrun_duty(duty) : head;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
      rep <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
      if (boundary) rep <= (rep == '0) ? REP_LAST : rep - RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      duty     <= MIDSCALE;
      underrun <= 1'b0;
    end else begin
      duty <= duty_eff;
      if (load && empty) underrun <= 1'b1;
    end
  end

  // Output stage: registered compare, one clk behind cnt.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) pwm_out <= 1'b0;
    else          pwm_out <= en && pwm_level(cnt, duty_eff);
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb_pwm_audio_out: table-driven, scoreboarded bench for pwm_audio_out (REPEAT=1 and REPEAT=3 instances).
module tb_pwm_audio_out;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int MID   = 128;

  typedef struct {
    logic [W-1:0] sample;
    int           exp_hi;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, s_valid, s_ready, pwm_out, underrun;
  logic [W-1:0]  s_data;
  logic [LW-1:0] fifo_level;
  logic          en2, s_valid2, s_ready2, pwm_out2, underrun2;
  logic [W-1:0]  s_data2;
  logic [LW-1:0] fifo_level2;

  int checks = 0;
  int errors = 0;
  int q1[$];
  int q2[$];
  int last1 = MID;
  int last2 = MID;

  vec_t t1[1];
  vec_t t2[3];
  vec_t t3[4];
  vec_t t5[2];

  always #5 clk = ~clk;

  pwm_audio_out #(.W(W), .DEPTH(DEPTH), .REPEAT(1)) dut (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .pwm_out(pwm_out), .fifo_level(fifo_level), .underrun(underrun)
  );

  pwm_audio_out #(.W(W), .DEPTH(DEPTH), .REPEAT(3)) dut_rep3 (
    .clk(clk), .rst(rst), .en(en2), .s_data(s_data2), .s_valid(s_valid2),
    .s_ready(s_ready2), .pwm_out(pwm_out2), .fifo_level(fifo_level2), .underrun(underrun2)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int empty_duty(input int last);
    empty_duty = last;
`ifdef PWM_UNDERRUN_MUTE_EN
    empty_duty = MID;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push1(input vec_t v);
    s_data  = v.sample;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    q1.push_back(v.exp_hi);
  endtask

  task automatic push2(input vec_t v);
    s_data2  = v.sample;
    s_valid2 = 1'b1;
    tick();
    s_valid2 = 1'b0;
    for (int k = 0; k < 3; k++) q2.push_back(v.exp_hi);
  endtask

  // Next edge must be a frame boundary; counts pwm highs over the 256 outputs that follow it.
  task automatic run_frame(input int sel, output int hi, output int lvl_b);
    tick();
    lvl_b = (sel == 1) ? int'(fifo_level) : int'(fifo_level2);
    hi    = (sel == 1) ? int'(pwm_out) : int'(pwm_out2);
    repeat (255) begin
      tick();
      hi += (sel == 1) ? int'(pwm_out) : int'(pwm_out2);
    end
  endtask

  task automatic score_frame(input int sel, input string name, output int lvl_b, output int und);
    int hi;
    int exp;
    run_frame(sel, hi, lvl_b);
    und = (sel == 1) ? int'(underrun) : int'(underrun2);
    if (sel == 1) begin
      exp   = (q1.size() > 0) ? q1.pop_front() : empty_duty(last1);
      last1 = exp;
    end else begin
      exp   = (q2.size() > 0) ? q2.pop_front() : empty_duty(last2);
      last2 = exp;
    end
    check(name, hi, exp);
  endtask

  initial begin
    int lvl;
    int und;
    int hi;
    int exp;

    t1[0] = '{8'h40, 64};
    t2[0] = '{8'h00, 0};
    t2[1] = '{8'hFF, 255};
    t2[2] = '{8'h80, 128};
    t3[0] = '{8'h10, 16};
    t3[1] = '{8'h30, 48};
    t3[2] = '{8'hF0, 240};
    t3[3] = '{8'h70, 112};
    t5[0] = '{8'h20, 32};
    t5[1] = '{8'h60, 96};

    rst = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = '0;
    en2 = 1'b0; s_valid2 = 1'b0; s_data2 = '0;
    repeat (3) tick();
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_ready", int'(s_ready), 1);
    check("rst_underrun", int'(underrun), 0);
    check("rst_level_rep3", int'(fifo_level2), 0);
    rst = 1'b1;
    repeat (2) tick();

    // REPEAT=3: each sample spans three frames, pops on boundaries 1 and 4
    for (int i = 0; i < 2; i++) push2(t5[i]);
    check("t5_level", int'(fifo_level2), 2);
    en2 = 1'b1;
    for (int f = 0; f < 6; f++) begin
      score_frame(2, "t5_hi", lvl, und);
      check("t5_level_b", lvl, (f < 3) ? 1 : 0);
      check("t5_underrun", und, 0);
    end
    score_frame(2, "t5_hold_hi", lvl, und);
    check("t5_underrun_set", und, 1);
    en2 = 1'b0;

    // Single sample, 64/256 duty
    push1(t1[0]);
    check("t1_level_pushed", int'(fifo_level), 1);
    check("t1_pwm_idle", int'(pwm_out), 0);
    en = 1'b1;
    score_frame(1, "t1_hi", lvl, und);
    check("t1_level_popped", lvl, 0);
    check("t1_underrun", und, 0);
    en = 1'b0;
    tick();

    // Extremes and midscale, then underrun on the fourth boundary
    for (int i = 0; i < 3; i++) push1(t2[i]);
    check("t2_level", int'(fifo_level), 3);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      score_frame(1, "t2_hi", lvl, und);
      check("t2_level_b", lvl, 2 - i);
      check("t2_underrun", und, 0);
    end
    score_frame(1, "t2_hold_hi", lvl, und);
    check("t2_underrun_set", und, 1);
    en = 1'b0;
    tick();

    // Fill while disabled; extra s_valid ignored
    for (int i = 0; i < 4; i++) push1(t3[i]);
    check("t3_level_full", int'(fifo_level), 4);
    check("t3_ready_low", int'(s_ready), 0);
    s_data  = 8'h99;
    s_valid = 1'b1;
    tick();
    check("t3_level_ignored", int'(fifo_level), 4);
    check("t3_pwm_disabled", int'(pwm_out), 0);

    // Push held across the load boundary is rejected, accepted one cycle later
    en = 1'b1;
    tick();
    check("t4_level_pop", int'(fifo_level), 3);
    check("t4_ready_rise", int'(s_ready), 1);
    hi = int'(pwm_out);
    tick();
    check("t4_level_refill", int'(fifo_level), 4);
    q1.push_back(8'h99);
    s_valid = 1'b0;
    hi += int'(pwm_out);
    repeat (254) begin
      tick();
      hi += int'(pwm_out);
    end
    exp   = q1.pop_front();
    last1 = exp;
    check("t4_hi", hi, exp);
    score_frame(1, "t4_next_hi", lvl, und);
    check("t4_next_level", lvl, 3);

    // Reset mid-frame with two entries queued
    tick();
    void'(q1.pop_front());
    repeat (100) tick();
    check("t6_level_before", int'(fifo_level), 2);
    check("t6_pwm_before", int'(pwm_out), 1);
    rst = 1'b0;
    #1;
    check("t6_pwm_rst", int'(pwm_out), 0);
    check("t6_level_rst", int'(fifo_level), 0);
    check("t6_ready_rst", int'(s_ready), 1);
    check("t6_underrun_rst", int'(underrun), 0);
    q1.delete();
    last1 = MID;
    en = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    check("t6_underrun_released", int'(underrun), 0);
    en = 1'b1;
    score_frame(1, "t6_mid_hi", lvl, und);
    check("t6_underrun_set", und, 1);
    check("t6_level_empty", lvl, 0);
    en = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_audio_out.md
Name: pwm_audio_out

Overview:
- Sample sink for the synth's 8-bit waveform output: converts `wav` samples into a 1-bit PWM stream for the board's audio pin / RC filter.
- Sits downstream of the waveform selector.
- Samples enter through a valid/ready handshake into a small FIFO that absorbs jitter between the sample producer and the fixed PWM frame rate.
- One sample is consumed per PWM frame (or per REPEAT frames).

Parameters:
- W, 8, sample and PWM counter width; frame length is 2^W clk cycles.
- DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.
- REPEAT, 1, number of consecutive PWM frames each sample is held for; range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  PWM run enable
- s_data  in  W  input sample, unsigned, midscale = 2^(W-1)
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO can accept; equals !full, combinational from FIFO level only
- pwm_out  out  1  registered PWM output
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- underrun  out  1  sticky; set when a frame boundary finds the FIFO empty

Behaviour:
- Reset (rst low, async): FIFO empty, fifo_level=0, s_ready=1, cnt=0, rep=0, duty=2^(W-1), pwm_out=0, underrun=0. Release is synchronised internally with a 2-flop deassert.
- Push: a sample is written on a clk edge with s_valid && s_ready. s_valid with s_ready low is ignored; the producer must hold s_data. Pushes are accepted regardless of en.
- Frame counter cnt (W bits):
  - Increments each clk while en=1 and wraps 2^W-1 -> 0.
  - The frame boundary is the cycle with en=1 and cnt==0.
- Repeat counter rep:
  - At each boundary, rep==0 means "load slot"; rep then advances to REPEAT-1 (or stays 0 when REPEAT=1).
  - Otherwise rep decrements.
- Load slot, FIFO non-empty: pop the head; duty <= head.
- Load slot, FIFO empty: duty holds its previous value, no pop, underrun <= 1.
  - A push in the same cycle does not bypass to the load; underrun is still set.
- Simultaneous push and pop: fifo_level is unchanged. A push into a full FIFO in the pop cycle is not accepted, because s_ready is computed before the pop.
- PWM compare:
  - On every enabled edge, pwm_out <= (cnt < duty_eff), where duty_eff is the newly loaded value at the boundary and duty otherwise.
  - pwm_out is high for exactly duty_eff cycles per 2^W-cycle frame, lagging cnt by one clk.
  - duty=0 gives constant low; duty=2^W-1 gives low for 1 cycle per frame.
- en low:
  - cnt and rep hold; pwm_out <= 0 on the next edge; no pops.
  - On re-enable, the frame resumes from the held cnt.
- underrun clears only on reset.
- Reset mid-frame discards the FIFO contents and the current duty.

Optional Feature:
- Macro: PWM_UNDERRUN_MUTE_EN.
- Defined: on an empty load slot, duty <= 2^(W-1) (midscale silence) instead of holding the last sample; underrun is still set.
- Not defined: the last duty is held as described above.

Test Plan:
1. Reset then push 0x40 with en=1, REPEAT=1 -> fifo_level 1 then 0 at the next cnt==0. pwm_out is high for exactly 64 of the following 256 cycles, starting one clk after the boundary.
2. Push 0x00, 0xFF, 0x80 back-to-back -> high counts per frame of 0, 255, 128. underrun stays 0 until the 4th boundary, where it becomes 1 and duty holds 0x80 (0x80 midscale also with PWM_UNDERRUN_MUTE_EN).
3. Fill FIFO with DEPTH=4 samples, en=0 -> s_ready=0, fifo_level=4. A fifth s_valid is ignored and pwm_out=0. At the first boundary after en=1, the level drops to 3 and s_ready rises.
4. Full FIFO with s_valid held at a load boundary -> that push is rejected; the push on the next cycle is accepted and the level returns to 4.
5. REPEAT=3, push 0x20, 0x60 -> three frames at 32 high cycles each, then three at 96. The pop occurs only on the 1st and 4th boundaries.
6. Assert rst low mid-frame while fifo_level=2 -> pwm_out=0, fifo_level=0, s_ready=1 immediately. After release with an empty FIFO and en=1, the first boundary sets underrun and pwm_out runs at 128/256.
